// File: rtl/fm_mod_pkg.sv
// Shared definitions for the FM modulator: FSM state type, fixed-point
// constants and the generator for the quarter-wave sine table.
package fm_mod_pkg;

  localparam int BITS          = 10;
  localparam int LUT_ADDR_BITS = 8;

  // pi * 2^30, the angle scale used while building the table
  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint ONE_Q30 = 64'sd1073741824;

  typedef enum logic [1:0] {
    S_READ,
    S_LOOKUP,
    S_WRITE
  } state_t;

  // round(sin(pi/2 * k / 2^addr_bits) * 2^bits), using a Q30 Taylor series so the
  // table is fixed at elaboration with integer arithmetic only
  function automatic int qsin_entry(input int k, input int bits, input int addr_bits);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (longint'(k) * PI_Q30) >>> (addr_bits + 1);
    x2   = (x * x) / ONE_Q30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) / ONE_Q30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'(((sum <<< bits) + (ONE_Q30 >>> 1)) >>> 30);
  endfunction

endpackage

// File: rtl/fm_sin_lut.sv
// Quarter-wave sine table with quadrant folding: turns the top phase bits
// into signed cos/sin words scaled by 2^FRAC_BITS.
module fm_sin_lut
  import fm_mod_pkg::*;
#(
  parameter int FRAC_BITS = 10,
  parameter int ADDR_BITS = 8
) (
  input  logic [ADDR_BITS+1:0]        phase_msb,
  output logic signed [FRAC_BITS+1:0] cos_out,
  output logic signed [FRAC_BITS+1:0] sin_out
);

  localparam int N = 2 ** ADDR_BITS + 1;
  localparam int M = N - 1;

  logic [FRAC_BITS:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam logic [FRAC_BITS:0] ENTRY = (FRAC_BITS + 1)'(qsin_entry(k, FRAC_BITS, ADDR_BITS));
    assign rom[k] = ENTRY;
  end

  logic [1:0]                  quad;
  logic [ADDR_BITS:0]          idx_a;
  logic [ADDR_BITS:0]          idx_m;
  logic signed [FRAC_BITS+1:0] l_a;
  logic signed [FRAC_BITS+1:0] l_m;

  // L[a] and L[M-a] are the only two reads; the quadrant picks signs and which one is cos
  always_comb begin
    quad    = phase_msb[ADDR_BITS+1:ADDR_BITS];
    idx_a   = {1'b0, phase_msb[ADDR_BITS-1:0]};
    idx_m   = (ADDR_BITS + 1)'(M) - idx_a;
    l_a     = signed'({1'b0, rom[idx_a]});
    l_m     = signed'({1'b0, rom[idx_m]});
    cos_out = l_m;
    sin_out = l_a;
    case (quad)
      2'd0: begin
        cos_out = l_m;
        sin_out = l_a;
      end
      2'd1: begin
        cos_out = -l_a;
        sin_out = l_m;
      end
      2'd2: begin
        cos_out = -l_m;
        sin_out = -l_a;
      end
      default: begin
        cos_out = l_a;
        sin_out = -l_m;
      end
    endcase
  end

endmodule

// File: rtl/fm_mod.sv
// FM modulator: pops samples, accumulates phase by sample*GAIN and pushes the
// matching cos/sin pair into the I and Q FIFOs, one sample every three cycles.
module fm_mod #(
  parameter int        DATA_WIDTH    = 32,
  parameter int        BITS          = fm_mod_pkg::BITS,
  parameter int        LUT_ADDR_BITS = fm_mod_pkg::LUT_ADDR_BITS,
  parameter int signed GAIN          = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] I_din,
  output logic                  I_wr_en,
  input  logic                  I_full,
  output logic [DATA_WIDTH-1:0] Q_din,
  output logic                  Q_wr_en,
  input  logic                  Q_full
);

  import fm_mod_pkg::*;

  localparam int PW = DATA_WIDTH + 32;

  state_t                state_q, state_d;
  logic [31:0]           phase_q, phase_d;
  logic [DATA_WIDTH-1:0] i_din_q, i_din_d;
  logic [DATA_WIDTH-1:0] q_din_q, q_din_d;
  logic [31:0]           incr;
  logic signed [BITS+1:0] lut_cos;
  logic signed [BITS+1:0] lut_sin;

  fm_sin_lut #(
    .FRAC_BITS(BITS),
    .ADDR_BITS(LUT_ADDR_BITS)
  ) u_lut (
    .phase_msb(phase_q[31:30-LUT_ADDR_BITS]),
    .cos_out  (lut_cos),
    .sin_out  (lut_sin)
  );

  // The pop is gated by reset so a held reset never drains the input FIFO
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    i_din_d  = i_din_q;
    q_din_d  = q_din_q;
    in_rd_en = 1'b0;
    I_wr_en  = 1'b0;
    Q_wr_en  = 1'b0;
    incr     = 32'(PW'(signed'(in_dout)) * PW'(GAIN));
    case (state_q)
      S_READ: begin
        if (!in_empty && !reset) begin
          in_rd_en = 1'b1;
          phase_d  = phase_q + incr;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        i_din_d = DATA_WIDTH'(lut_cos);
        q_din_d = DATA_WIDTH'(lut_sin);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!I_full && !Q_full) begin
          I_wr_en = 1'b1;
          Q_wr_en = 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      phase_q <= '0;
      i_din_q <= '0;
      q_din_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      i_din_q <= i_din_d;
      q_din_q <= q_din_d;
    end
  end

  assign I_din = i_din_q;
  assign Q_din = q_din_q;

endmodule

// File: tb/tb_fm_mod.sv
// Self-checking bench for fm_mod: directed and random samples compared against
// an ideal-trigonometry phase-accumulator model.
module tb_fm_mod;

  localparam int  DW   = 32;
  localparam int  GAIN = 1;
  localparam real PI   = 3.14159265358979323846;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_dout = '0;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] I_din;
  logic [DW-1:0] Q_din;
  logic          I_wr_en;
  logic          Q_wr_en;
  logic          I_full = 1'b0;
  logic          Q_full = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int checked  = 0;

  logic [DW-1:0] in_fifo[$];
  bit            pop_pending = 1'b0;
  int            pop_cycles[$];
  int            wr_cycles[$];
  logic [DW-1:0] wr_i[$];
  logic [DW-1:0] wr_q[$];
  bit            wr_ok[$];

  logic [31:0]   model_phase = '0;
  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_q[$];
  int            exp_lat[$];

  fm_mod #(
    .DATA_WIDTH(DW),
    .GAIN      (GAIN)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_dout (in_dout),
    .in_empty(in_empty),
    .in_rd_en(in_rd_en),
    .I_din   (I_din),
    .I_wr_en (I_wr_en),
    .I_full  (I_full),
    .Q_din   (Q_din),
    .Q_wr_en (Q_wr_en),
    .Q_full  (Q_full)
  );

  always #5 clock = ~clock;

  // Ideal oscillator: the output angle is the phase truncated to the 10 bits the table resolves
  function automatic logic [DW-1:0] ref_word(input logic [31:0] phase, input bit want_sin);
    int  p;
    real ang;
    real v;
    p   = int'(phase >> 22);
    ang = 2.0 * PI * real'(p) / 1024.0;
    v   = want_sin ? $sin(ang) : $cos(ang);
    return DW'($rtoi($floor(v * 1024.0 + 0.5)));
  endfunction

  function automatic void refresh_in();
    in_empty = (in_fifo.size() == 0);
    in_dout  = in_empty ? '0 : in_fifo[0];
  endfunction

  // Record every pop and every write as seen mid-cycle
  always @(negedge clock) begin
    cyc++;
    if (in_rd_en) begin
      pop_cycles.push_back(cyc);
      pop_pending = 1'b1;
    end
    if (I_wr_en || Q_wr_en) begin
      wr_cycles.push_back(cyc);
      wr_i.push_back(I_din);
      wr_q.push_back(Q_din);
      wr_ok.push_back(I_wr_en && Q_wr_en && !I_full && !Q_full);
    end
  end

  // First-word fall-through input FIFO
  always @(posedge clock) begin
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      void'(in_fifo.pop_front());
      refresh_in();
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] s, input int lat);
    in_fifo.push_back(s);
    refresh_in();
    model_phase = model_phase + 32'(longint'(signed'(s)) * longint'(GAIN));
    exp_i.push_back(ref_word(model_phase, 1'b0));
    exp_q.push_back(ref_word(model_phase, 1'b1));
    exp_lat.push_back(lat);
  endtask

  task automatic waitWrites(input string tag);
    int budget;
    budget = 300;
    while (wr_cycles.size() < exp_i.size() && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    checkOutput({tag, "_count"}, 32'(wr_cycles.size()), 32'(exp_i.size()));
    while (checked < exp_i.size() && checked < wr_cycles.size()) begin
      checkOutput({tag, "_I"}, wr_i[checked], exp_i[checked]);
      checkOutput({tag, "_Q"}, wr_q[checked], exp_q[checked]);
      checkOutput({tag, "_paired"}, 32'(wr_ok[checked]), 32'd1);
      if (exp_lat[checked] >= 0)
        checkOutput({tag, "_latency"}, 32'(wr_cycles[checked] - pop_cycles[checked]),
                    32'(exp_lat[checked]));
      checked++;
    end
  endtask

  initial begin
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    int            base;
    int            budget;
    int            idx;

    refresh_in();
    reset = 1'b1;
    applyStimulus(32'h0000_0000, 2);
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset_rd_en", 32'(in_rd_en), 32'd0);
    checkOutput("reset_I_wr_en", 32'(I_wr_en), 32'd0);
    checkOutput("reset_Q_wr_en", 32'(Q_wr_en), 32'd0);
    checkOutput("reset_I_din", I_din, 32'd0);
    checkOutput("reset_Q_din", Q_din, 32'd0);

    $display("[TB] zero sample");
    tick();
    reset = 1'b0;
    waitWrites("zero");
    checkOutput("zero_I_const", wr_i[0], 32'h0000_0400);
    checkOutput("zero_Q_const", wr_q[0], 32'h0000_0000);
    repeat (4) tick();
    checkOutput("zero_single_pop", 32'(pop_cycles.size()), 32'd1);

    $display("[TB] quarter-turn steps");
    tick();
    base = pop_cycles.size();
    repeat (3) applyStimulus(32'h4000_0000, 2);
    waitWrites("quarter");
    checkOutput("quarter1_I", wr_i[base], 32'h0000_0000);
    checkOutput("quarter1_Q", wr_q[base], 32'h0000_0400);
    checkOutput("quarter2_I", wr_i[base+1], 32'hFFFF_FC00);
    checkOutput("quarter2_Q", wr_q[base+1], 32'h0000_0000);
    checkOutput("quarter3_I", wr_i[base+2], 32'h0000_0000);
    checkOutput("quarter3_Q", wr_q[base+2], 32'hFFFF_FC00);

    $display("[TB] negative wrap from phase 0");
    tick();
    applyStimulus(32'h4000_0000, 2);
    applyStimulus(32'hC000_0000, 2);
    waitWrites("negwrap");
    checkOutput("negwrap_I_const", wr_i[checked-1], 32'h0000_0000);
    checkOutput("negwrap_Q_const", wr_q[checked-1], 32'hFFFF_FC00);

    $display("[TB] Q FIFO stall");
    tick();
    I_full = 1'b0;
    Q_full = 1'b1;
    s1 = $urandom;
    s2 = $urandom;
    applyStimulus(s1, 7);
    applyStimulus(s2, 2);
    idx  = exp_i.size() - 2;
    base = pop_cycles.size();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      checkOutput("stall_I_wr_en", 32'(I_wr_en), 32'd0);
      checkOutput("stall_Q_wr_en", 32'(Q_wr_en), 32'd0);
      checkOutput("stall_rd_en", 32'(in_rd_en), 32'd0);
      checkOutput("stall_I_hold", I_din, exp_i[idx]);
      checkOutput("stall_Q_hold", Q_din, exp_q[idx]);
      tick();
    end
    checkOutput("stall_pops", 32'(pop_cycles.size() - base), 32'd1);
    Q_full = 1'b0;
    waitWrites("stall");

    $display("[TB] back-to-back random samples");
    tick();
    base = pop_cycles.size();
    repeat (4) applyStimulus($urandom, 2);
    waitWrites("b2b");
    for (int k = 1; k < 4; k++)
      checkOutput("b2b_pop_gap", 32'(pop_cycles[base+k] - pop_cycles[base+k-1]), 32'd3);

    $display("[TB] random samples with random back-pressure");
    tick();
    repeat (8) applyStimulus($urandom, -1);
    budget = 0;
    while (wr_cycles.size() < exp_i.size() && budget < 400) begin
      tick();
      I_full = ($urandom_range(0, 2) == 0);
      Q_full = ($urandom_range(0, 2) == 0);
      budget++;
    end
    I_full = 1'b0;
    Q_full = 1'b0;
    waitWrites("rand_stall");

    $display("[TB] reset during lookup");
    tick();
    base = pop_cycles.size();
    in_fifo.push_back($urandom | 32'h0100_0000);
    refresh_in();
    tick();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_I_din", I_din, 32'd0);
    checkOutput("midreset_Q_din", Q_din, 32'd0);
    checkOutput("midreset_I_wr_en", 32'(I_wr_en), 32'd0);
    checkOutput("midreset_Q_wr_en", 32'(Q_wr_en), 32'd0);
    checkOutput("midreset_rd_en", 32'(in_rd_en), 32'd0);
    checkOutput("midreset_popped", 32'(pop_cycles.size() - base), 32'd1);
    repeat (2) tick();
    reset = 1'b0;
    model_phase = '0;
    void'(pop_cycles.pop_back());
    repeat (3) tick();
    checkOutput("midreset_no_write", 32'(wr_cycles.size()), 32'(exp_i.size()));
    applyStimulus(32'h0000_0000, 2);
    waitWrites("post_reset");
    checkOutput("post_reset_I_const", wr_i[checked-1], 32'h0000_0400);
    checkOutput("post_reset_Q_const", wr_q[checked-1], 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
